// File: rtl/async_fifo.sv
// Single-clock FIFO with dcfifo-compatible port names, registered read data
// and status flags decoded from a registered word count.
module async_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  wrfull,
    output logic                  rdfull,
    output logic                  empty,
    output logic [AW:0]           usedw
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW:0]           count;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wrfull = (count == (AW+1)'(DEPTH));
    assign rdfull = wrfull;
    assign empty  = (count == '0);
    assign usedw  = count;

    // Gating on the registered flags means a simultaneous request on an
    // empty FIFO never reads through the word being written.
    assign wr_ok = wrreq & ~wrfull;
    assign rd_ok = rdreq & ~empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wptr] <= data;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            q     <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                q    <= mem[rptr];
                rptr <= rptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: a reference queue tracks accepted writes,
// reads pop the expected word and every cycle checks q and the status flags.
module tb_async_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clock;
    logic          aclr_n;
    logic [DW-1:0] data;
    logic          wrreq;
    logic          rdreq;
    logic [DW-1:0] q;
    logic          wrfull;
    logic          rdfull;
    logic          empty;
    logic [AW:0]   usedw;

    async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock  (clock),
        .aclr_n (aclr_n),
        .data   (data),
        .wrreq  (wrreq),
        .rdreq  (rdreq),
        .q      (q),
        .wrfull (wrfull),
        .rdfull (rdfull),
        .empty  (empty),
        .usedw  (usedw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".q"},      32'(q),      32'(exp_q));
        chk({tag, ".usedw"},  32'(usedw),  32'(sb.size()));
        chk({tag, ".empty"},  32'(empty),  32'(sb.size() == 0));
        chk({tag, ".wrfull"}, 32'(wrfull), 32'(sb.size() == DEPTH));
        chk({tag, ".rdfull"}, 32'(rdfull), 32'(sb.size() == DEPTH));
    endtask

    // One clock: drive requests, update the reference model with what the
    // FIFO should accept, then sample just after the edge.
    task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
        bit wacc;
        bit racc;
        wrreq = w;
        rdreq = r;
        data  = d;
        wacc  = w && (sb.size() < DEPTH);
        racc  = r && (sb.size() > 0);
        if (racc) exp_q = sb.pop_front();
        if (wacc) sb.push_back(d);
        @(posedge clock);
        #1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        chk_status(tag);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 2 * DEPTH) begin
            step(tag, 1'b0, 1'b1, '0);
            guard++;
        end
    endtask

    initial begin
        aclr_n = 1'b0;
        wrreq  = 1'b0;
        rdreq  = 1'b0;
        data   = '0;
        exp_q  = '0;

        repeat (2) @(posedge clock);
        #1;
        chk_status("reset");
        #3 aclr_n = 1'b1;

        for (int i = 1; i <= 10; i++) step("fill", 1'b1, 1'b0, DW'(i));
        chk("fill.usedw10", 32'(usedw), 32'd10);
        for (int i = 1; i <= 10; i++) begin
            step("drain", 1'b0, 1'b1, '0);
            chk("drain.order", 32'(q), 32'(i));
        end

        for (int i = 0; i < 17; i++) step("ovf", 1'b1, 1'b0, DW'(16'h0100 + i));
        chk("ovf.full", 32'(wrfull), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step("ovf_rd", 1'b0, 1'b1, '0);
            chk("ovf_rd.order", 32'(q), 32'(16'h0100 + i));
        end

        for (int i = 0; i < 3; i++) step("udf", 1'b0, 1'b1, '0);
        chk("udf.qhold", 32'(q), 32'h010F);

        for (int i = 0; i < 5; i++) step("sim5_wr", 1'b1, 1'b0, DW'(16'h0200 + i));
        for (int i = 5; i < 9; i++) step("sim5_both", 1'b1, 1'b1, DW'(16'h0200 + i));
        chk("sim5.usedw", 32'(usedw), 32'd5);
        drain("sim5_drain");

        for (int i = 0; i < DEPTH; i++) step("full_wr", 1'b1, 1'b0, DW'(16'h0300 + i));
        step("full_both", 1'b1, 1'b1, 16'hDEAD);
        chk("full_both.usedw", 32'(usedw), 32'd15);
        drain("full_drain");

        step("empty_both", 1'b1, 1'b1, 16'h0A5A);
        chk("empty_both.usedw", 32'(usedw), 32'd1);
        drain("empty_drain");

        begin
            int wr_n;
            int burst;
            wr_n  = 0;
            burst = 0;
            while (wr_n < 40) begin
                for (int k = 0; k < (burst % 5) + 1 && wr_n < 40; k++) begin
                    step("wrap_wr", 1'b1, 1'b0, DW'(16'h1000 + wr_n));
                    wr_n++;
                end
                for (int k = 0; k < (burst % 4) + 1; k++) step("wrap_rd", 1'b0, 1'b1, '0);
                if (burst % 3 == 0) step("wrap_both", 1'b1, 1'b1, DW'(16'h2000 + burst));
                burst++;
            end
            drain("wrap_drain");
        end

        for (int i = 0; i < 7; i++) step("mid_wr", 1'b1, 1'b0, DW'(16'h0400 + i));
        #2 aclr_n = 1'b0;
        sb.delete();
        exp_q = '0;
        #1;
        chk_status("mid_rst_async");
        wrreq = 1'b1;
        data  = 16'h1234;
        @(posedge clock);
        #1;
        wrreq = 1'b0;
        chk_status("mid_rst_held");
        #3 aclr_n = 1'b1;
        step("beef_wr", 1'b1, 1'b0, 16'hBEEF);
        step("beef_rd", 1'b0, 1'b1, '0);
        chk("beef.q", 32'(q), 32'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
